// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Unsigned magnitude; the most negative value maps onto itself, which is exact as unsigned.
    function automatic logic [MD_WIDTH-1:0] abs_val(input logic [MD_WIDTH-1:0] x,
                                                    input logic              is_signed);
        return (is_signed && x[MD_WIDTH-1]) ? ((~x) + MD_WIDTH'(1)) : x;
    endfunction

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a {upper(WIDTH+1), lower(WIDTH)} accumulator.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [2*WIDTH:0]  i_acc,
    input  logic [WIDTH-1:0]  i_operand,
    input  logic              i_is_div,
    output logic [2*WIDTH:0]  o_acc
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [2*WIDTH:0] w_shl;

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        w_sum   = i_acc[0] ? (i_acc[2*WIDTH:WIDTH] + {1'b0, i_operand}) : i_acc[2*WIDTH:WIDTH];
        w_shl   = {i_acc[2*WIDTH-1:0], 1'b0};
        w_trial = w_shl[2*WIDTH:WIDTH] - {1'b0, i_operand};
        o_acc   = w_shl;
        if (i_is_div) begin
            // Non-negative trial difference means the divisor fits: keep it and set the quotient bit.
            if (!w_trial[WIDTH]) begin
                o_acc = {w_trial, w_shl[WIDTH-1:1], 1'b1};
            end
        end else begin
            o_acc = {1'b0, w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO write access.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;
    logic [2*WIDTH:0] r_acc;
    logic [WIDTH-1:0] r_operand;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    op_e              w_op;
    logic             w_is_div;
    logic             w_is_signed;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [2*WIDTH:0] w_next_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    always_comb begin
        w_op        = op_e'(Op);
        w_is_div    = op_is_div(w_op);
        w_is_signed = op_is_signed(w_op);
        w_sign_a    = w_is_signed & OperandA[WIDTH-1];
        w_sign_b    = w_is_signed & OperandB[WIDTH-1];
        w_mag_a     = abs_val(OperandA, w_is_signed);
        w_mag_b     = abs_val(OperandB, w_is_signed);

        w_prod = r_neg_q ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
        w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        // A zero divisor leaves |dividend| in the remainder, so the sign rule already restores OperandA.
        if (r_div_zero) begin
            w_quo = '1;
        end
        w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .i_is_div  (r_is_div),
        .o_acc     (w_next_acc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_acc      <= '0;
            r_operand  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (WriteHi) r_hi <= WriteData;
                    if (WriteLo) r_lo <= WriteData;
                    if (Start) begin
                        r_is_div   <= w_is_div;
                        r_neg_q    <= w_sign_a ^ w_sign_b;
                        r_neg_r    <= w_sign_a;
                        r_div_zero <= w_is_div && (OperandB == '0);
                        // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
                        r_acc      <= {{(WIDTH+1){1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                        r_operand  <= w_is_div ? w_mag_b : w_mag_a;
                        r_count    <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_next_acc;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == LAST_ITER) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_dbz   <= r_div_zero;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign Hi        = r_hi;
    assign Lo        = r_lo;

endmodule
